// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input conditioner.
//   - channel index constants into the level vector
//   - default timing constants, in clk_1khz cycles (1 cycle = 1 ms)
//   - state enums for the btn_2 auto-repeat and btn_3 long-press FSMs
//   - cnt_width(): counter width that holds 0..max_count
package panel_pkg;

  localparam int unsigned CH_BTN1   = 0;
  localparam int unsigned CH_BTN2   = 1;
  localparam int unsigned CH_BTN3   = 2;
  localparam int unsigned CH_HOPPER = 3;

  localparam int unsigned DEF_DEBOUNCE_MS        = 20;
  localparam int unsigned DEF_HOPPER_DEBOUNCE_MS = 5;
  localparam int unsigned DEF_HOLD_MS            = 600;
  localparam int unsigned DEF_REPEAT_MS          = 150;
  localparam int unsigned DEF_LONG_MS            = 2000;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_HOLD   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  typedef enum logic [1:0] {
    LP_IDLE    = 2'd0,
    LP_TIMING  = 2'd1,
    LP_LATCHED = 2'd2
  } long_state_t;

  // ceil(log2(max_count + 1)), never less than one bit
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input channel: optional inversion, 2-FF synchroniser,
// debounce counter, accepted-level register and registered rise pulse.
// Ports:
//   clk_1khz   in   system clock
//   switch_clr in   asynchronous active-low reset
//   raw        in   asynchronous raw input
//   level      out  debounced level (after optional inversion)
//   rise       out  one-cycle pulse the cycle after level goes 0->1
module debounce_channel
  import panel_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 20,
  parameter bit          INVERT        = 1'b0
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_MAX = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 0;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  logic             din;
  logic             s1;
  logic             s2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  assign din = raw ^ INVERT;

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= din;
      s2      <= s1;
      level_d <= level;
      rise    <= level & ~level_d;
      // The counter can never pass CNT_MAX: reaching it either accepts
      // the new level or the mismatch has already gone and it clears.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(CNT_MAX)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner. Debounces three buttons and the hopper
// level, and turns clean presses into single-cycle strobes on clk_1khz.
// btn_2 auto-repeats while held. btn_3 also reports a long press.
// Ports:
//   clk_1khz         in   1 ms system clock
//   switch_clr       in   asynchronous active-low reset
//   btn_1_raw        in   position-select button, active-high
//   btn_2_raw        in   increment button, active-high
//   btn_3_raw        in   start/clear button, active-low
//   hopper_level_raw in   hopper drop signal, active-high
//   btn_1_pulse      out  strobe on accepted btn_1 press
//   btn_2_pulse      out  strobe on btn_2 press and on each auto-repeat
//   btn_3_pulse      out  strobe on accepted btn_3 press
//   btn_3_long       out  strobe once btn_3 has been held LONG_MS
//   hopper_pulse     out  strobe on accepted hopper rising edge
//   level            out  debounced {hopper, btn_3, btn_2, btn_1}, pressed = 1
//
// rep FSM (btn_2)
//   state      | meaning
//   REP_IDLE   | waiting for a press; the press strobe is emitted here
//   REP_HOLD   | held, counting down HOLD_MS to the first repeat
//   REP_REPEAT | held, a strobe every REPEAT_MS
// long FSM (btn_3)
//   state      | meaning
//   LP_IDLE    | waiting for a press; the press strobe is emitted here
//   LP_TIMING  | held, counting down LONG_MS
//   LP_LATCHED | long strobe already sent, waiting for release
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS        = DEF_DEBOUNCE_MS,
  parameter int unsigned HOPPER_DEBOUNCE_MS = DEF_HOPPER_DEBOUNCE_MS,
  parameter int unsigned HOLD_MS            = DEF_HOLD_MS,
  parameter int unsigned REPEAT_MS          = DEF_REPEAT_MS,
  parameter int unsigned LONG_MS            = DEF_LONG_MS
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       btn_1_raw,
  input  logic       btn_2_raw,
  input  logic       btn_3_raw,
  input  logic       hopper_level_raw,
  output logic       btn_1_pulse,
  output logic       btn_2_pulse,
  output logic       btn_3_pulse,
  output logic       btn_3_long,
  output logic       hopper_pulse,
  output logic [3:0] level
);

  // Down-counter reload values: the timer runs reload..0, so a strobe
  // lands exactly *_MS cycles after the cycle that loaded it.
  localparam int unsigned HOLD_LOAD   = (HOLD_MS > 0) ? HOLD_MS - 1 : 0;
  localparam int unsigned REPEAT_LOAD = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
  localparam int unsigned LONG_LOAD   = (LONG_MS > 0) ? LONG_MS - 1 : 0;
  localparam int unsigned REP_MAX     = (HOLD_LOAD > REPEAT_LOAD) ? HOLD_LOAD : REPEAT_LOAD;
  localparam int unsigned REP_W       = cnt_width(REP_MAX);
  localparam int unsigned LONG_W      = cnt_width(LONG_LOAD);

  logic [3:0] lvl;
  logic [3:0] rise;

  debounce_channel #(.STABLE_CYCLES(DEBOUNCE_MS), .INVERT(1'b0)) u_btn1 (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .raw        (btn_1_raw),
    .level      (lvl[CH_BTN1]),
    .rise       (rise[CH_BTN1])
  );

  debounce_channel #(.STABLE_CYCLES(DEBOUNCE_MS), .INVERT(1'b0)) u_btn2 (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .raw        (btn_2_raw),
    .level      (lvl[CH_BTN2]),
    .rise       (rise[CH_BTN2])
  );

  // btn_3 idles high; inverting it up front makes pressed = 1 everywhere.
  debounce_channel #(.STABLE_CYCLES(DEBOUNCE_MS), .INVERT(1'b1)) u_btn3 (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .raw        (btn_3_raw),
    .level      (lvl[CH_BTN3]),
    .rise       (rise[CH_BTN3])
  );

  debounce_channel #(.STABLE_CYCLES(HOPPER_DEBOUNCE_MS), .INVERT(1'b0)) u_hopper (
    .clk_1khz   (clk_1khz),
    .switch_clr (switch_clr),
    .raw        (hopper_level_raw),
    .level      (lvl[CH_HOPPER]),
    .rise       (rise[CH_HOPPER])
  );

  assign level        = lvl;
  assign btn_1_pulse  = rise[CH_BTN1];
  assign hopper_pulse = rise[CH_HOPPER];

  // btn_2 auto-repeat
  rep_state_t       rep_state;
  rep_state_t       rep_next;
  logic [REP_W-1:0] rep_timer;
  logic [REP_W-1:0] rep_timer_next;

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      rep_state <= REP_IDLE;
      rep_timer <= '0;
    end else begin
      rep_state <= rep_next;
      rep_timer <= rep_timer_next;
    end
  end

  always_comb begin
    rep_next       = rep_state;
    rep_timer_next = (rep_timer != '0) ? rep_timer - 1'b1 : '0;
    btn_2_pulse    = 1'b0;
    case (rep_state)
      REP_IDLE: begin
        if (rise[CH_BTN2]) begin
          btn_2_pulse    = 1'b1;
          rep_next       = REP_HOLD;
          rep_timer_next = REP_W'(HOLD_LOAD);
        end
      end
      REP_HOLD: begin
        if (!lvl[CH_BTN2]) begin
          rep_next = REP_IDLE;
        end else if (rep_timer == '0) begin
          btn_2_pulse    = 1'b1;
          rep_next       = REP_REPEAT;
          rep_timer_next = REP_W'(REPEAT_LOAD);
        end
      end
      REP_REPEAT: begin
        // Release wins over a due repeat so nothing fires after letting go.
        if (!lvl[CH_BTN2]) begin
          rep_next = REP_IDLE;
        end else if (rep_timer == '0) begin
          btn_2_pulse    = 1'b1;
          rep_timer_next = REP_W'(REPEAT_LOAD);
        end
      end
      default: begin
        rep_next = REP_IDLE;
      end
    endcase
  end

  // btn_3 long press
  long_state_t       long_state;
  long_state_t       long_next;
  logic [LONG_W-1:0] long_timer;
  logic [LONG_W-1:0] long_timer_next;

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      long_state <= LP_IDLE;
      long_timer <= '0;
    end else begin
      long_state <= long_next;
      long_timer <= long_timer_next;
    end
  end

  always_comb begin
    long_next       = long_state;
    long_timer_next = (long_timer != '0) ? long_timer - 1'b1 : '0;
    btn_3_pulse     = 1'b0;
    btn_3_long      = 1'b0;
    case (long_state)
      LP_IDLE: begin
        if (rise[CH_BTN3]) begin
          btn_3_pulse     = 1'b1;
          long_next       = LP_TIMING;
          long_timer_next = LONG_W'(LONG_LOAD);
        end
      end
      LP_TIMING: begin
        if (!lvl[CH_BTN3]) begin
          long_next = LP_IDLE;
        end else if (long_timer == '0) begin
          btn_3_long = 1'b1;
          long_next  = LP_LATCHED;
        end
      end
      LP_LATCHED: begin
        if (!lvl[CH_BTN3]) begin
          long_next = LP_IDLE;
        end
      end
      default: begin
        long_next = LP_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_panel_input_conditioner.sv
module tb_panel_input_conditioner;

  logic       clk_1khz = 1'b0;
  logic       switch_clr;
  logic       btn_1_raw;
  logic       btn_2_raw;
  logic       btn_3_raw;
  logic       hopper_level_raw;
  logic       btn_1_pulse;
  logic       btn_2_pulse;
  logic       btn_3_pulse;
  logic       btn_3_long;
  logic       hopper_pulse;
  logic [3:0] level;

  panel_input_conditioner dut (
    .clk_1khz         (clk_1khz),
    .switch_clr       (switch_clr),
    .btn_1_raw        (btn_1_raw),
    .btn_2_raw        (btn_2_raw),
    .btn_3_raw        (btn_3_raw),
    .hopper_level_raw (hopper_level_raw),
    .btn_1_pulse      (btn_1_pulse),
    .btn_2_pulse      (btn_2_pulse),
    .btn_3_pulse      (btn_3_pulse),
    .btn_3_long       (btn_3_long),
    .hopper_pulse     (hopper_pulse),
    .level            (level)
  );

  always #5 clk_1khz = ~clk_1khz;

  int cyc = 0;
  always @(posedge clk_1khz) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  int    exp_q[5][$];
  string names[5] = '{"btn_1_pulse", "btn_2_pulse", "btn_3_pulse", "btn_3_long", "hopper_pulse"};
  logic [4:0] p;
  int    base;

  // Scoreboard: each strobe seen must be the head entry of its queue.
  always @(negedge clk_1khz) begin
    if (mon_en) begin
      p = {hopper_pulse, btn_3_long, btn_3_pulse, btn_2_pulse, btn_1_pulse};
      for (int i = 0; i < 5; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missing: got none at cycle %0d, required pulse", names[i], exp_q[i][0]);
          void'(exp_q[i].pop_front());
        end
        if (p[i] !== 1'b0) begin
          checks++;
          if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
            void'(exp_q[i].pop_front());
          end else begin
            errors++;
            $display("FAIL %s unexpected: got %b at cycle %0d, required 0", names[i], p[i], cyc);
          end
        end
      end
    end
  end

  // rel = cycle number counted from the first edge after stimulus at base
  function automatic int at_rel(input int rel);
    return base + 1 + rel;
  endfunction

  task automatic step();
    @(negedge clk_1khz);
    #1;
  endtask

  task automatic test_reset();
    switch_clr = 1'b0;
    btn_1_raw = 1'b0; btn_2_raw = 1'b0; btn_3_raw = 1'b1; hopper_level_raw = 1'b0;
    repeat (3) step();
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL reset_level got %b required 0000", level); end
    checks++;
    if ({btn_1_pulse, btn_2_pulse, btn_3_pulse, btn_3_long, hopper_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b required 00000", {btn_1_pulse, btn_2_pulse, btn_3_pulse, btn_3_long, hopper_pulse});
    end
    switch_clr = 1'b1;
    mon_en = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_btn1_press();
    base = cyc;
    btn_1_raw = 1'b1;
    exp_q[0].push_back(at_rel(22));
    for (int k = 0; k < 60; k++) begin
      step();
      if (k == 20) begin
        checks++; if (level[0] !== 1'b0) begin errors++; $display("FAIL btn1_level_c20 got %b required 0", level[0]); end
      end
      if (k == 21) begin
        checks++; if (level !== 4'b0001) begin errors++; $display("FAIL btn1_level_c21 got %b required 0001", level); end
      end
      if (k == 29) btn_1_raw = 1'b0;
    end
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL btn1_release_level got %b required 0000", level); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL btn1_drain %s got %0d pending required 0", names[i], exp_q[i].size()); exp_q[i].delete(); end
    end
  endtask

  task automatic test_glitch();
    base = cyc;
    btn_2_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == 9) btn_2_raw = 1'b0;
      checks++; if (level[1] !== 1'b0) begin errors++; $display("FAIL glitch_level got %b at rel %0d required 0", level[1], k); end
    end
  endtask

  task automatic test_repeat();
    base = cyc;
    btn_2_raw = 1'b1;
    exp_q[1].push_back(at_rel(22));
    exp_q[1].push_back(at_rel(622));
    exp_q[1].push_back(at_rel(772));
    exp_q[1].push_back(at_rel(922));
    for (int k = 0; k < 1150; k++) begin
      step();
      if (k == 999) btn_2_raw = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL repeat_drain %s got %0d pending required 0", names[i], exp_q[i].size()); exp_q[i].delete(); end
    end
  endtask

  task automatic test_long_press();
    base = cyc;
    btn_3_raw = 1'b0;
    exp_q[2].push_back(at_rel(22));
    exp_q[3].push_back(at_rel(2022));
    for (int k = 0; k < 2600; k++) begin
      step();
      if (k == 21) begin
        checks++; if (level !== 4'b0100) begin errors++; $display("FAIL btn3_level got %b required 0100", level); end
      end
      if (k == 2499) btn_3_raw = 1'b1;
    end
    base = cyc;
    btn_3_raw = 1'b0;
    exp_q[2].push_back(at_rel(22));
    for (int k = 0; k < 2200; k++) begin
      step();
      if (k == 499) btn_3_raw = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL long_drain %s got %0d pending required 0", names[i], exp_q[i].size()); exp_q[i].delete(); end
    end
  endtask

  task automatic test_hopper_simultaneous();
    base = cyc;
    hopper_level_raw = 1'b1;
    btn_1_raw = 1'b1;
    exp_q[4].push_back(at_rel(7));
    exp_q[4].push_back(at_rel(1007));
    exp_q[0].push_back(at_rel(22));
    for (int k = 0; k < 2050; k++) begin
      step();
      if (k == 6) begin
        checks++; if (level !== 4'b1000) begin errors++; $display("FAIL hopper_level_c6 got %b required 1000", level); end
      end
      if (k == 21) begin
        checks++; if (level !== 4'b1001) begin errors++; $display("FAIL both_level_c21 got %b required 1001", level); end
      end
      if (k == 49)   btn_1_raw = 1'b0;
      if (k == 499)  hopper_level_raw = 1'b0;
      if (k == 999)  hopper_level_raw = 1'b1;
      if (k == 1499) hopper_level_raw = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL hopper_drain %s got %0d pending required 0", names[i], exp_q[i].size()); exp_q[i].delete(); end
    end
  endtask

  task automatic test_reset_mid_press();
    base = cyc;
    btn_2_raw = 1'b1;
    exp_q[1].push_back(at_rel(22));
    for (int k = 0; k < 300; k++) step();
    switch_clr = 1'b0;
    #1;
    checks++; if (level !== 4'b0000) begin errors++; $display("FAIL midreset_level got %b required 0000", level); end
    checks++;
    if ({btn_1_pulse, btn_2_pulse, btn_3_pulse, btn_3_long, hopper_pulse} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_pulses got %b required 00000", {btn_1_pulse, btn_2_pulse, btn_3_pulse, btn_3_long, hopper_pulse});
    end
    step();
    switch_clr = 1'b1;
    base = cyc;
    exp_q[1].push_back(at_rel(22));
    for (int k = 0; k < 120; k++) begin
      step();
      if (k == 20) begin
        checks++; if (level[1] !== 1'b0) begin errors++; $display("FAIL midreset_redebounce got %b required 0", level[1]); end
      end
      if (k == 49) btn_2_raw = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin errors++; $display("FAIL midreset_drain %s got %0d pending required 0", names[i], exp_q[i].size()); exp_q[i].delete(); end
    end
  endtask

  initial begin
    test_reset();
    test_btn1_press();
    test_glitch();
    test_repeat();
    test_long_press();
    test_hopper_simultaneous();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
